// File: rtl/board_scan_sched_pkg.sv
// ----------------------------------------------------------------------------
// board_scan_sched_pkg
//   Shared constants and the refresh FSM encoding for the board scan
//   scheduler and its statistics accumulator.
// ----------------------------------------------------------------------------
package board_scan_sched_pkg;

    localparam int ADDR_W  = 11;             // board RAM address width
    localparam int DATA_W  = 32;             // tile code width
    localparam int SCORE_W = 32;             // score width, wraps mod 2^32
    localparam int N_TILES = 16;             // 4x4 board, row-major
    localparam int IDX_W   = 4;              // cell index width

    localparam logic [ADDR_W-1:0] BOARD_BASE = 11'd256;   // address of cell 0

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/board_stat_acc.sv
// ----------------------------------------------------------------------------
// board_stat_acc
//   Running unsigned sum and maximum of a stream of tile codes.
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     i_clr        zero both accumulators (wins over i_en)
//     i_en         fold i_data into sum and max this cycle
//     i_data       tile code
//     o_sum        running sum, wraps mod 2^SCORE_W
//     o_max        running unsigned maximum
// ----------------------------------------------------------------------------
module board_stat_acc
    import board_scan_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [DATA_W-1:0]  i_data,
    output logic [SCORE_W-1:0] o_sum,
    output logic [DATA_W-1:0]  o_max
);

    logic [SCORE_W-1:0] r_sum;
    logic [DATA_W-1:0]  r_max;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= '0;
            r_max <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
            r_max <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + SCORE_W'(i_data);
            if (i_data > r_max) begin
                r_max <= i_data;
            end
        end
    end

    assign o_sum = r_sum;
    assign o_max = r_max;

endmodule

// File: rtl/board_scan_sched.sv
// ----------------------------------------------------------------------------
// board_scan_sched
//   Arbitrates the single board RAM port between game-logic writes and a
//   once-per-vblank refresh of a 16-entry tile shadow used by the pixel path.
//   Also publishes a frame-stable score (sum of codes) and max tile code.
//   Ports:
//     clk, rst            clock, asynchronous active-low reset
//     vblank              vertical blank level; refresh starts on its rise
//     force_refresh       refresh on next vblank rise even if board is clean
//     wr_req/idx/data     game write request, held until wr_ack
//     wr_ack              write accepted this cycle (same cycle as ram_we)
//     ram_addr/we/wdata   board RAM port
//     ram_rdata           board RAM read data, one cycle after ram_addr
//     disp_idx/disp_code  combinational shadow lookup for the pixel path
//     score, max_code     statistics of the last completed refresh
//     busy                refresh in progress
//     refresh_done        one-cycle pulse in the final refresh cycle;
//                         score/max_code load at the end of that cycle
// ----------------------------------------------------------------------------
module board_scan_sched
    import board_scan_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               vblank,
    input  logic               force_refresh,
    input  logic               wr_req,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ack,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    input  logic [IDX_W-1:0]   disp_idx,
    output logic [DATA_W-1:0]  disp_code,
    output logic [SCORE_W-1:0] score,
    output logic [DATA_W-1:0]  max_code,
    output logic               busy,
    output logic               refresh_done
);

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_k;
    logic               r_vblank_q;
    logic               r_dirty;
    logic [DATA_W-1:0]  r_shadow [N_TILES];
    logic [SCORE_W-1:0] r_score;
    logic [DATA_W-1:0]  r_max_code;

    logic               w_start;
    logic               w_wr_fire;
    logic               w_cap_en;
    logic [IDX_W-1:0]   w_cap_idx;
    logic [SCORE_W-1:0] w_acc_sum;
    logic [DATA_W-1:0]  w_acc_max;

    assign w_start   = vblank & ~r_vblank_q & (r_dirty | force_refresh)
                     & (r_state == ST_IDLE);
    // A refresh starting this cycle owns the port; the write waits.
    assign w_wr_fire = wr_req & ~w_start & (r_state == ST_IDLE);

    // Read data lags the address by one cycle: cell k lands while the FSM is
    // at k+1, and cell 15 lands in DRAIN where r_k has wrapped to 0, so
    // r_k-1 names the arriving cell in every capture cycle.
    assign w_cap_en  = ((r_state == ST_RD) && (r_k != '0)) || (r_state == ST_DRAIN);
    assign w_cap_idx = r_k - IDX_W'(1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next_state = ST_RD;
            ST_RD:    if (r_k == IDX_W'(N_TILES - 1)) w_next_state = ST_DRAIN;
            ST_DRAIN: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ram_addr     = '0;
        ram_we       = 1'b0;
        ram_wdata    = '0;
        wr_ack       = 1'b0;
        busy         = (r_state != ST_IDLE);
        refresh_done = (r_state == ST_DONE);
        if (r_state == ST_RD) begin
            ram_addr = BOARD_BASE + ADDR_W'(r_k);
        end else if (w_wr_fire) begin
            ram_addr  = BOARD_BASE + ADDR_W'(wr_idx);
            ram_we    = 1'b1;
            ram_wdata = wr_data;
            wr_ack    = 1'b1;
        end
    end

    // ---------------- Control registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k        <= '0;
            r_vblank_q <= 1'b0;
            r_dirty    <= 1'b1;     // first vblank after reset always refreshes
        end else begin
            r_vblank_q <= vblank;
            r_k        <= (r_state == ST_RD) ? r_k + IDX_W'(1) : '0;
            if (w_start) begin
                r_dirty <= 1'b0;
            end else if (w_wr_fire) begin
                r_dirty <= 1'b1;
            end
        end
    end

    // ---------------- Shadow and published statistics ----------------
    // NOTE: the shadow is a flop array, not a RAM, so it can be reset; a
    // reset mid-refresh must leave the pixel path reading zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_TILES; i++) begin
                r_shadow[i] <= '0;
            end
            r_score    <= '0;
            r_max_code <= '0;
        end else begin
            if (w_cap_en) begin
                r_shadow[w_cap_idx] <= ram_rdata;
            end
            if (r_state == ST_DONE) begin
                r_score    <= w_acc_sum;
                r_max_code <= w_acc_max;
            end
        end
    end

    board_stat_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_en   (w_cap_en),
        .i_data (ram_rdata),
        .o_sum  (w_acc_sum),
        .o_max  (w_acc_max)
    );

    assign disp_code = r_shadow[disp_idx];
    assign score     = r_score;
    assign max_code  = r_max_code;

endmodule

// File: tb/tb_board_scan_sched.sv
// ----------------------------------------------------------------------------
// tb_board_scan_sched
//   Self-checking bench for board_scan_sched with a behavioural board RAM.
//   Expected RAM reads/writes go into scoreboard queues when stimulus is
//   driven; a monitor pops and compares them as the DUT drives the port.
// ----------------------------------------------------------------------------
module tb_board_scan_sched;

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic        force_refresh;
    logic        wr_req;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [3:0]  disp_idx;
    logic [31:0] disp_code;
    logic [31:0] score;
    logic [31:0] max_code;
    logic        busy;
    logic        refresh_done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;

    logic [10:0] exp_rd_q [$];
    wr_t         exp_wr_q [$];
    logic [31:0] exp_sh   [16];
    logic [31:0] mem      [0:2047];
    wr_t         mon_w;
    logic [10:0] mon_a;

    board_scan_sched dut (
        .clk           (clk),
        .rst           (rst),
        .vblank        (vblank),
        .force_refresh (force_refresh),
        .wr_req        (wr_req),
        .wr_idx        (wr_idx),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .disp_idx      (disp_idx),
        .disp_code     (disp_code),
        .score         (score),
        .max_code      (max_code),
        .busy          (busy),
        .refresh_done  (refresh_done)
    );

    always #5 clk = ~clk;

    // Board RAM: one-cycle registered read.
    always @(posedge clk) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Port monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            n_checks++;
            if (wr_ack !== ram_we) begin
                n_errors++;
                $display("FAIL ack_vs_we: wr_ack=%b ram_we=%b (must match)", wr_ack, ram_we);
            end
            if (ram_we === 1'b1) begin
                n_checks++;
                if (exp_wr_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL write_unexpected: addr=%0d data=%0d, none expected", ram_addr, ram_wdata);
                end else begin
                    mon_w = exp_wr_q.pop_front();
                    if (ram_addr !== mon_w.addr || ram_wdata !== mon_w.data) begin
                        n_errors++;
                        $display("FAIL write_port: got addr=%0d data=%0d, want addr=%0d data=%0d",
                                 ram_addr, ram_wdata, mon_w.addr, mon_w.data);
                    end
                end
            end
            if (busy === 1'b1 && ram_addr !== 11'd0) begin
                n_checks++;
                if (exp_rd_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL read_unexpected: addr=%0d, none expected", ram_addr);
                end else begin
                    mon_a = exp_rd_q.pop_front();
                    if (ram_addr !== mon_a || ram_we !== 1'b0) begin
                        n_errors++;
                        $display("FAIL read_port: got addr=%0d we=%b, want addr=%0d we=0",
                                 ram_addr, ram_we, mon_a);
                    end
                end
            end
            if (refresh_done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_reads();
        for (int i = 0; i < 16; i++) exp_rd_q.push_back(11'(256 + i));
    endtask

    task automatic start_vblank(input logic frc);
        tick();
        vblank        = 1'b1;
        force_refresh = frc;
    endtask

    task automatic end_vblank();
        tick();
        vblank        = 1'b0;
        force_refresh = 1'b0;
    endtask

    task automatic check_zero_outputs(input string name);
        n_checks++;
        if ({busy, refresh_done, wr_ack, ram_we, ram_addr, ram_wdata, score, max_code} !== '0) begin
            n_errors++;
            $display("FAIL %s: busy=%b done=%b ack=%b we=%b addr=%0d wdata=%0d score=%0d max=%0d, want all 0",
                     name, busy, refresh_done, wr_ack, ram_we, ram_addr, ram_wdata, score, max_code);
        end
    endtask

    task automatic check_disp(input string name);
        for (int i = 0; i < 16; i++) begin
            disp_idx = 4'(i);
            #1;
            n_checks++;
            if (disp_code !== exp_sh[i]) begin
                n_errors++;
                $display("FAIL %s: disp_idx=%0d got %0d want %0d", name, i, disp_code, exp_sh[i]);
            end
        end
    endtask

    // Called right after the vblank rise is driven; first negedge is the
    // start cycle. Expected statistics come from the bench RAM contents.
    task automatic wait_refresh(input int inject_at, input logic [3:0] inj_idx,
                                input logic [31:0] inj_data, input logic exp_ack);
        logic [31:0] es;
        logic [31:0] em;
        int          lat;
        bit          saw_ack;
        bit          saw_busy;
        es = 0;
        em = 0;
        for (int i = 0; i < 16; i++) begin
            exp_sh[i] = mem[256 + i];
            es += mem[256 + i];
            if (mem[256 + i] > em) em = mem[256 + i];
        end
        lat = -1;
        saw_ack = 0;
        saw_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == inject_at) begin
                n_checks++;
                if (ram_addr !== 11'(256 + inject_at - 1)) begin
                    n_errors++;
                    $display("FAIL inject_point: addr=%0d want %0d", ram_addr, 256 + inject_at - 1);
                end
                wr_req  = 1'b1;
                wr_idx  = inj_idx;
                wr_data = inj_data;
                exp_wr_q.push_back('{addr: 11'(256 + inj_idx), data: inj_data});
            end
            if (refresh_done === 1'b1) begin
                lat = i;
                break;
            end
            if (wr_ack !== 1'b0) saw_ack = 1;
            if (busy === 1'b1) saw_busy = 1;
        end
        n_checks++;
        if (lat != 18) begin
            n_errors++;
            $display("FAIL refresh_latency: got %0d cycles want 18 (-1 = timeout)", lat);
        end
        n_checks++;
        if (!saw_busy || saw_ack) begin
            n_errors++;
            $display("FAIL refresh_busy_ack: busy_seen=%0d ack_seen=%0d want 1/0", saw_busy, saw_ack);
        end
        @(negedge clk);
        n_checks++;
        if (refresh_done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL refresh_end: done=%b busy=%b want 0/0", refresh_done, busy);
        end
        n_checks++;
        if (score !== es || max_code !== em) begin
            n_errors++;
            $display("FAIL stats: score=%0d max=%0d want %0d/%0d", score, max_code, es, em);
        end
        n_checks++;
        if (wr_ack !== exp_ack) begin
            n_errors++;
            $display("FAIL stalled_ack: wr_ack=%b want %b", wr_ack, exp_ack);
        end
        n_checks++;
        if (exp_rd_q.size() != 0) begin
            n_errors++;
            $display("FAIL reads_missing: %0d expected reads not seen", exp_rd_q.size());
            exp_rd_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("reset_outputs");
        for (int i = 0; i < 16; i++) exp_sh[i] = 0;
        check_disp("reset_shadow");
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_refresh_basic();
        push_reads();
        start_vblank(1'b0);
        wait_refresh(-1, 4'd0, 32'd0, 1'b0);
        n_checks++;
        if (score !== 32'd120 || max_code !== 32'd15) begin
            n_errors++;
            $display("FAIL basic_stats: score=%0d max=%0d want 120/15", score, max_code);
        end
        check_disp("basic_shadow");
        end_vblank();
    endtask

    task automatic test_write_during_rd();
        push_reads();
        start_vblank(1'b1);
        wait_refresh(5, 4'd3, 32'd7, 1'b1);
        tick();
        wr_req = 1'b0;
        end_vblank();
        n_checks++;
        if (exp_wr_q.size() != 0 || mem[259] !== 32'd7) begin
            n_errors++;
            $display("FAIL stalled_write: pending=%0d mem[259]=%0d want 0/7", exp_wr_q.size(), mem[259]);
        end
    endtask

    task automatic test_clean_skip();
        int  d0;
        bit  saw_busy;
        push_reads();
        start_vblank(1'b0);
        wait_refresh(-1, 4'd0, 32'd0, 1'b0);
        end_vblank();
        d0 = done_cnt;
        saw_busy = 0;
        start_vblank(1'b0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1;
        end
        n_checks++;
        if (saw_busy || done_cnt != d0) begin
            n_errors++;
            $display("FAIL clean_skip: busy_seen=%0d extra_done=%0d want 0/0", saw_busy, done_cnt - d0);
        end
        end_vblank();
        push_reads();
        start_vblank(1'b1);
        wait_refresh(-1, 4'd0, 32'd0, 1'b0);
        n_checks++;
        if (score !== 32'd124) begin
            n_errors++;
            $display("FAIL forced_stats: score=%0d want 124", score);
        end
        end_vblank();
    endtask

    task automatic test_back_to_back();
        exp_wr_q.push_back('{addr: 11'd256, data: 32'd100});
        exp_wr_q.push_back('{addr: 11'd257, data: 32'd1});
        tick();
        wr_req = 1'b1; wr_idx = 4'd0; wr_data = 32'd100;
        @(negedge clk);
        n_checks++;
        if (wr_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_ack0: wr_ack=%b want 1", wr_ack);
        end
        tick();
        wr_idx = 4'd1; wr_data = 32'd1;
        @(negedge clk);
        n_checks++;
        if (wr_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_ack1: wr_ack=%b want 1", wr_ack);
        end
        tick();
        wr_req = 1'b0;
        // write and vblank rise in the same cycle: refresh first
        push_reads();
        exp_wr_q.push_back('{addr: 11'd271, data: 32'd200});
        start_vblank(1'b0);
        wr_req = 1'b1; wr_idx = 4'd15; wr_data = 32'd200;
        wait_refresh(-1, 4'd0, 32'd0, 1'b1);
        n_checks++;
        if (score !== 32'd224 || max_code !== 32'd100) begin
            n_errors++;
            $display("FAIL collide_stats: score=%0d max=%0d want 224/100", score, max_code);
        end
        tick();
        wr_req = 1'b0;
        end_vblank();
        push_reads();
        start_vblank(1'b0);
        wait_refresh(-1, 4'd0, 32'd0, 1'b0);
        n_checks++;
        if (score !== 32'd409 || max_code !== 32'd200) begin
            n_errors++;
            $display("FAIL next_frame_stats: score=%0d max=%0d want 409/200", score, max_code);
        end
        end_vblank();
    endtask

    task automatic test_reset_mid_rd();
        bit found;
        push_reads();
        start_vblank(1'b1);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ram_addr === 11'd264) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL reach_k8: addr 264 not seen");
        end
        rst = 1'b0;
        #1;
        check_zero_outputs("midrun_reset_outputs");
        exp_rd_q.delete();
        vblank = 1'b0;
        force_refresh = 1'b0;
        for (int i = 0; i < 16; i++) exp_sh[i] = 0;
        check_disp("midrun_reset_shadow");
        tick();
        rst = 1'b1;
        push_reads();
        start_vblank(1'b0);
        wait_refresh(-1, 4'd0, 32'd0, 1'b0);
        check_disp("post_reset_shadow");
        end_vblank();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
        for (int i = 0; i < 16; i++) mem[256 + i] = 32'(i);
        ram_rdata     = 32'd0;
        vblank        = 1'b0;
        force_refresh = 1'b0;
        wr_req        = 1'b0;
        wr_idx        = 4'd0;
        wr_data       = 32'd0;
        disp_idx      = 4'd0;

        test_reset();
        test_refresh_basic();
        test_write_during_rd();
        test_clean_skip();
        test_back_to_back();
        test_reset_mid_rd();

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
